// File: rtl/wb_struct_pkg.sv
// Shared Wishbone definitions: bus direction encodings, default widths and
// the slave-memory FSM state type.
package wb_struct_pkg;

   localparam logic READ  = 1'b0;
   localparam logic WRITE = 1'b1;

   localparam int WB_ADDR_W            = 10;
   localparam int WB_DATA_W            = 32;
   localparam int WB_CNT_W             = 16;
   localparam int WB_SLV_DEPTH_DEFAULT = 256;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      TERM = 2'd2
   } wb_slv_state_e;

endpackage

// File: rtl/wb_slave_mem_bytearray.sv
// Byte-lane memory: one inferred RAM per lane, per-lane write enable and a
// registered read that holds its value when no read is requested.
module wb_slave_mem_bytearray
   import wb_struct_pkg::*;
#(
   parameter int SEL_W = 4,
   parameter int DEPTH = WB_SLV_DEPTH_DEFAULT,
   parameter int AW    = 8
)(
   input  logic               clk,
   input  logic [AW-1:0]      adr,
   input  logic               we,
   input  logic [SEL_W-1:0]   sel,
   input  logic [SEL_W*8-1:0] wdat,
   input  logic               re,
   output logic [SEL_W*8-1:0] rdat
);

   genvar gi;
   generate
      for (gi = 0; gi < SEL_W; gi++) begin : g_lane
         logic [7:0] mem [DEPTH];
         logic [7:0] rd_reg;

         always_ff @(posedge clk) begin
            if (we && sel[gi]) begin
               mem[adr] <= wdat[gi*8 +: 8];
            end
            if (re) begin
               rd_reg <= mem[adr];
            end
         end

         assign rdat[gi*8 +: 8] = rd_reg;
      end
   endgenerate

endmodule

// File: rtl/wb_slave_mem.sv
// Wishbone classic-cycle slave memory with programmable wait states,
// out-of-range error termination and saturating per-type access counters.
module wb_slave_mem
   import wb_struct_pkg::*;
#(
   parameter int ADDR_W      = WB_ADDR_W,
   parameter int DATA_W      = WB_DATA_W,
   parameter int DEPTH       = WB_SLV_DEPTH_DEFAULT,
   parameter int WAIT_STATES = 0,
   parameter int CNT_W       = WB_CNT_W,
   localparam int SEL_W      = DATA_W / 8
)(
   input  logic              wb_clk_i,
   input  logic              wb_rst_n_i,
   input  logic [ADDR_W-1:0] wb_adr_i,
   input  logic [DATA_W-1:0] wb_dat_i,
   input  logic [SEL_W-1:0]  wb_sel_i,
   input  logic              wb_we_i,
   input  logic              wb_cyc_i,
   input  logic              wb_stb_i,
   output logic [DATA_W-1:0] wb_dat_o,
   output logic              wb_ack_o,
   output logic              wb_err_o,
   output logic [CNT_W-1:0]  rd_cnt_o,
   output logic [CNT_W-1:0]  wr_cnt_o,
   output logic [CNT_W-1:0]  err_cnt_o
);

   localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   wb_slv_state_e     state_reg;
   logic [3:0]        wait_cnt_reg;
   logic [ADDR_W-1:0] adr_reg;
   logic [DATA_W-1:0] dat_reg;
   logic [SEL_W-1:0]  sel_reg;
   logic              we_reg;
   logic              ack_reg;
   logic              err_reg;
   logic              dat_valid_reg;
   logic [CNT_W-1:0]  rd_cnt_reg;
   logic [CNT_W-1:0]  wr_cnt_reg;
   logic [CNT_W-1:0]  err_cnt_reg;

   logic              req;
   logic              commit;
   logic              in_range;
   logic              ram_we;
   logic              ram_re;
   logic [DATA_W-1:0] ram_rdat;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   // The latched request always spends at least one cycle in WAIT so that the
   // termination is registered; the counter then adds WAIT_STATES more.
   assign req      = wb_cyc_i & wb_stb_i;
   assign commit   = (state_reg == WAIT) && req && (wait_cnt_reg == 4'd0);
   assign in_range = ({1'b0, adr_reg} < (ADDR_W+1)'(DEPTH));
   assign ram_we   = commit && in_range && (we_reg == WRITE);
   assign ram_re   = commit && in_range && (we_reg == READ);

   wb_slave_mem_bytearray #(
      .SEL_W (SEL_W),
      .DEPTH (DEPTH),
      .AW    (RAM_AW)
   ) u_bytearray (
      .clk  (wb_clk_i),
      .adr  (adr_reg[RAM_AW-1:0]),
      .we   (ram_we),
      .sel  (sel_reg),
      .wdat (dat_reg),
      .re   (ram_re),
      .rdat (ram_rdat)
   );

   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         state_reg     <= IDLE;
         wait_cnt_reg  <= 4'd0;
         adr_reg       <= '0;
         dat_reg       <= '0;
         sel_reg       <= '0;
         we_reg        <= READ;
         ack_reg       <= 1'b0;
         err_reg       <= 1'b0;
         dat_valid_reg <= 1'b0;
         rd_cnt_reg    <= '0;
         wr_cnt_reg    <= '0;
         err_cnt_reg   <= '0;
      end else begin
         ack_reg <= 1'b0;
         err_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (req) begin
                  adr_reg      <= wb_adr_i;
                  dat_reg      <= wb_dat_i;
                  sel_reg      <= wb_sel_i;
                  we_reg       <= wb_we_i;
                  wait_cnt_reg <= 4'(WAIT_STATES);
                  state_reg    <= WAIT;
               end
            end
            WAIT: begin
               if (!req) begin
                  state_reg <= IDLE;
               end else if (wait_cnt_reg != 4'd0) begin
                  wait_cnt_reg <= wait_cnt_reg - 4'd1;
               end else begin
                  state_reg <= TERM;
                  if (!in_range) begin
                     err_reg       <= 1'b1;
                     err_cnt_reg   <= sat_inc(err_cnt_reg);
                     dat_valid_reg <= 1'b0;
                  end else if (we_reg == WRITE) begin
                     ack_reg    <= 1'b1;
                     wr_cnt_reg <= sat_inc(wr_cnt_reg);
                  end else begin
                     ack_reg       <= 1'b1;
                     rd_cnt_reg    <= sat_inc(rd_cnt_reg);
                     dat_valid_reg <= 1'b1;
                  end
               end
            end
            TERM: begin
               state_reg <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   // The RAM read register is not reset, so reset/error zeroing is a mask.
   assign wb_dat_o  = dat_valid_reg ? ram_rdat : '0;
   assign wb_ack_o  = ack_reg;
   assign wb_err_o  = err_reg;
   assign rd_cnt_o  = rd_cnt_reg;
   assign wr_cnt_o  = wr_cnt_reg;
   assign err_cnt_o = err_cnt_reg;

endmodule
